// File: rtl/rv_timer_alarm_pkg.sv
// Purpose: shared types and constants for the rv_timer virtual-alarm scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package rv_timer_alarm_pkg;

    typedef enum logic {
        ALARM_ARM    = 1'b0,
        ALARM_CANCEL = 1'b1
    } alarm_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        PROGRAM = 3'd2,
        SETTLE  = 3'd3,
        WAIT    = 3'd4
    } sched_state_e;

    // Compare value that can never fire in practice; used when no slot is armed.
    localparam logic [63:0] CMP_IDLE = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rv_timer_alarm_sched.sv
// Purpose: multiplexes N virtual alarms onto one mtimecmp by serial min-scan.
// Latency: ARM handshake to cmp write N_ALARMS+1 cycles; intr to expiry 1..N_ALARMS.
// Backpressure: req_ready_o low while scanning, programming or settling.
module rv_timer_alarm_sched
    import rv_timer_alarm_pkg::*;
#(
    parameter int N_ALARMS   = 4,
    parameter int IDW        = $clog2(N_ALARMS),
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_op_i,
    input  logic [IDW-1:0]      req_id_i,
    input  logic [63:0]         req_deadline_i,
    input  logic [63:0]         mtime_i,
    input  logic                timer_intr_i,
    output logic [63:0]         cmp_o,
    output logic                cmp_we_o,
    output logic [N_ALARMS-1:0] armed_o,
    output logic [N_ALARMS-1:0] expired_o,
    output logic                busy_o
);

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    sched_state_e          state_q, state_d;
    logic [N_ALARMS-1:0]   armed_q;
    logic [63:0]           deadline_q [N_ALARMS];
    logic [IDW-1:0]        idx_q;
    logic [63:0]           min_q;
    logic                  min_vld_q;
    logic [SCW-1:0]        settle_q;
    logic [63:0]           cmp_q;

    logic                  req_fire;
    logic [63:0]           cur_dl;
    logic                  cur_armed;
    logic                  cur_hit;
    logic                  cur_better;
    logic                  scan_last;
    logic                  settle_last;
    logic [63:0]           cmp_new;

    // Per-slot evaluation for the slot currently under the scan pointer.
    always_comb begin
        req_fire    = req_valid_i && req_ready_o;
        cur_dl      = deadline_q[idx_q];
        cur_armed   = armed_q[idx_q];
        cur_hit     = (state_q == SCAN) && cur_armed && (cur_dl <= mtime_i);
        // Strict less-than keeps the lower index on equal deadlines.
        cur_better  = (state_q == SCAN) && cur_armed && !cur_hit &&
                      (!min_vld_q || (cur_dl < min_q));
        scan_last   = (idx_q == IDW'(N_ALARMS - 1));
        settle_last = (settle_q == SCW'(SETTLE_CYC - 1));
        // After a full scan, min_vld_q is set exactly when some slot is still armed.
        cmp_new     = min_vld_q ? min_q : CMP_IDLE;
    end

    // Outputs: the compare value is presented combinationally during PROGRAM
    // so the write strobe and data line up in the same cycle.
    always_comb begin
        req_ready_o = (state_q == IDLE) || (state_q == WAIT);
        busy_o      = !req_ready_o;
        cmp_we_o    = (state_q == PROGRAM);
        cmp_o       = cmp_we_o ? cmp_new : cmp_q;
        armed_o     = armed_q;
        // Suppressed while reset is asserted so an aborted scan emits nothing.
        expired_o   = (cur_hit && rst_ni) ? (N_ALARMS'(1) << idx_q) : '0;
    end

    // Next-state logic; timer_intr_i only matters in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_fire) state_d = SCAN;
            WAIT:    if (req_fire || timer_intr_i) state_d = SCAN;
            SCAN:    if (scan_last) state_d = PROGRAM;
            PROGRAM: state_d = min_vld_q ? SETTLE : IDLE;
            SETTLE:  if (settle_last) state_d = WAIT;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, scan pointer, running minimum and settle counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            min_q     <= '0;
            min_vld_q <= 1'b0;
            settle_q  <= '0;
            cmp_q     <= CMP_IDLE;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE, WAIT: begin
                    // Any scan entry (request or interrupt) starts from a clean minimum.
                    if (state_d == SCAN) begin
                        idx_q     <= '0;
                        min_q     <= '0;
                        min_vld_q <= 1'b0;
                    end
                end
                SCAN: begin
                    idx_q <= scan_last ? '0 : idx_q + 1'b1;
                    if (cur_better) begin
                        min_q     <= cur_dl;
                        min_vld_q <= 1'b1;
                    end
                end
                PROGRAM: begin
                    cmp_q    <= cmp_new;
                    settle_q <= '0;
                end
                SETTLE: begin
                    settle_q <= settle_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Slot storage: requests only land in IDLE/WAIT, retirements only in SCAN,
    // so the two update paths never collide on the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            armed_q <= '0;
            for (int i = 0; i < N_ALARMS; i++) begin
                deadline_q[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                if (req_op_i == ALARM_ARM) begin
                    armed_q[req_id_i]    <= 1'b1;
                    deadline_q[req_id_i] <= req_deadline_i;
                end else begin
                    armed_q[req_id_i]    <= 1'b0;
                end
            end
            if (cur_hit) begin
                armed_q[idx_q] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv_timer_alarm_sched.sv
// Purpose: directed self-checking bench for rv_timer_alarm_sched (N_ALARMS=4).
// Latency: inputs driven 1 time unit after posedge, outputs checked there.
// Backpressure: requests are only offered when the scheduler is idle/waiting.
module tb_rv_timer_alarm_sched;
    import rv_timer_alarm_pkg::*;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [1:0]  req_id;
    logic [63:0] req_deadline;
    logic [63:0] mtime;
    logic        intr;
    logic [63:0] cmp;
    logic        cmp_we;
    logic [3:0]  armed;
    logic [3:0]  expired;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    logic [3:0] seen;
    logic       any_act;

    always #5 clk = ~clk;

    rv_timer_alarm_sched #(
        .N_ALARMS   (4),
        .IDW        (2),
        .SETTLE_CYC (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_id_i       (req_id),
        .req_deadline_i (req_deadline),
        .mtime_i        (mtime),
        .timer_intr_i   (intr),
        .cmp_o          (cmp),
        .cmp_we_o       (cmp_we),
        .armed_o        (armed),
        .expired_o      (expired),
        .busy_o         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one request for exactly one cycle; returns just after the accepting edge.
    task automatic do_req(input logic op, input logic [1:0] id, input logic [63:0] dl);
        req_valid    = 1'b1;
        req_op       = op;
        req_id       = id;
        req_deadline = dl;
        #0;
        chk("req_ready", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    // From SCAN idx0, count cycles until the compare write, collecting expiry pulses.
    task automatic to_program(output int n, output logic [3:0] s);
        n = 0;
        s = 4'b0;
        while (cmp_we !== 1'b1 && n < 40) begin
            s = s | expired;
            step();
            n++;
        end
    endtask

    // From PROGRAM (with slots armed) through SETTLE into WAIT.
    task automatic to_wait(input string tag);
        step();
        step();
        step();
        chk(tag, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_op       = 1'b0;
        req_id       = 2'd0;
        req_deadline = 64'd0;
        mtime        = 64'd0;
        intr         = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset / idle state
        chk("rst_cmp",     cmp, ONES);
        chk("rst_cmp_we",  {63'd0, cmp_we}, 64'd0);
        chk("rst_ready",   {63'd0, req_ready}, 64'd1);
        chk("rst_armed",   {60'd0, armed}, 64'd0);
        chk("rst_expired", {60'd0, expired}, 64'd0);
        chk("rst_busy",    {63'd0, busy}, 64'd0);

        // ARM slot2 = 1000 at mtime 0
        do_req(ALARM_ARM, 2'd2, 64'd1000);
        chk("arm2_busy", {63'd0, busy}, 64'd1);
        chk("arm2_ready", {63'd0, req_ready}, 64'd0);
        to_program(lat, seen);
        chk("arm2_lat", 64'(lat), 64'd4);
        chk("arm2_seen", {60'd0, seen}, 64'd0);
        chk("arm2_cmp", cmp, 64'd1000);
        chk("arm2_armed", {60'd0, armed}, 64'b0100);
        step();
        chk("arm2_we_drop", {63'd0, cmp_we}, 64'd0);
        chk("arm2_cmp_hold", cmp, 64'd1000);
        step();
        step();
        chk("arm2_wait", {63'd0, busy}, 64'd0);

        // ARM slot0 = 500, then slot3 = 500
        do_req(ALARM_ARM, 2'd0, 64'd500);
        to_program(lat, seen);
        chk("arm0_cmp", cmp, 64'd500);
        to_wait("arm0_wait");
        do_req(ALARM_ARM, 2'd3, 64'd500);
        to_program(lat, seen);
        chk("arm3_cmp", cmp, 64'd500);
        chk("arm3_armed", {60'd0, armed}, 64'b1101);
        to_wait("arm3_wait");

        // Timer fires at mtime 500: slots 0 and 3 expire (deadline == mtime)
        mtime = 64'd500;
        intr  = 1'b1;
        step();
        intr  = 1'b0;
        chk("intr_exp_scan0", {60'd0, expired}, 64'b0001);
        to_program(lat, seen);
        chk("intr_lat", 64'(lat), 64'd4);
        chk("intr_seen", {60'd0, seen}, 64'b1001);
        chk("intr_cmp", cmp, 64'd1000);
        chk("intr_armed", {60'd0, armed}, 64'b0100);
        to_wait("intr_wait");

        // ARM a deadline already in the past
        do_req(ALARM_ARM, 2'd1, 64'd10);
        to_program(lat, seen);
        chk("past_seen", {60'd0, seen}, 64'b0010);
        chk("past_cmp", cmp, 64'd1000);
        chk("past_armed", {60'd0, armed}, 64'b0100);
        to_wait("past_wait");

        // CANCEL the only armed slot, then the interrupt is ignored in IDLE
        do_req(ALARM_CANCEL, 2'd2, 64'd0);
        to_program(lat, seen);
        chk("cancel_seen", {60'd0, seen}, 64'd0);
        chk("cancel_cmp", cmp, ONES);
        chk("cancel_armed", {60'd0, armed}, 64'd0);
        step();
        chk("cancel_idle", {63'd0, busy}, 64'd0);
        intr    = 1'b1;
        any_act = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            any_act = any_act | busy | cmp_we | (|expired);
        end
        intr = 1'b0;
        chk("idle_intr_ignored", {63'd0, any_act}, 64'd0);

        // All-ones deadline stays armed; interrupt held through SETTLE
        do_req(ALARM_ARM, 2'd1, ONES);
        to_program(lat, seen);
        chk("ones_cmp", cmp, ONES);
        chk("ones_armed", {60'd0, armed}, 64'b0010);
        intr = 1'b1;
        step();
        chk("settle1_busy", {63'd0, busy}, 64'd1);
        step();
        chk("settle2_busy", {63'd0, busy}, 64'd1);
        step();
        chk("settle_to_wait", {63'd0, busy}, 64'd0);
        step();
        chk("wait_intr_scan", {63'd0, busy}, 64'd1);
        intr = 1'b0;
        to_program(lat, seen);
        chk("ones_rescan_lat", 64'(lat), 64'd4);
        chk("ones_rescan_seen", {60'd0, seen}, 64'd0);
        chk("ones_rescan_cmp", cmp, ONES);
        to_wait("ones_wait");

        // Three slots armed, then reset during a scan that would expire slot0
        mtime = 64'd0;
        do_req(ALARM_ARM, 2'd0, 64'd100);
        to_program(lat, seen);
        chk("r_arm0_cmp", cmp, 64'd100);
        to_wait("r_arm0_wait");
        do_req(ALARM_ARM, 2'd2, 64'd200);
        to_program(lat, seen);
        chk("r_arm2_cmp", cmp, 64'd100);
        chk("r_armed3", {60'd0, armed}, 64'b0111);
        to_wait("r_arm2_wait");
        mtime = 64'd1000;
        intr  = 1'b1;
        step();
        rst_n = 1'b0;
        #0;
        chk("rst_cycle_no_pulse", {60'd0, expired}, 64'd0);
        step();
        intr = 1'b0;
        chk("midrst_armed", {60'd0, armed}, 64'd0);
        chk("midrst_cmp", cmp, ONES);
        chk("midrst_cmp_we", {63'd0, cmp_we}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_expired", {60'd0, expired}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", {63'd0, busy}, 64'd0);
        chk("post_rst_armed", {60'd0, armed}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_timer_alarm_sched.md
Name: rv_timer_alarm_sched

Overview:
Schedules N software/hardware "virtual alarms" onto the single 64-bit mtimecmp comparator of one rv_timer hart.
- Keeps one deadline per slot and scans the slots serially.
- Programs the comparator with the earliest pending deadline.
- On the timer interrupt, retires every expired slot with a one-cycle pulse.
- Sits beside rv_timer: drives the compare-register write path and consumes mtime and intr_timer_expired.

Parameters:
- N_ALARMS, 4, number of alarm slots (>=2).
- IDW, $clog2(N_ALARMS), slot id width.
- SETTLE_CYC, 2, cycles after a compare write during which timer_intr_i is ignored (covers the intr_state clear plus the registered intr_o).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- req_valid_i  in  1  alarm request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_op_i  in  1  0=ARM, 1=CANCEL
- req_id_i  in  IDW  target slot
- req_deadline_i  in  64  absolute mtime deadline (ARM only)
- mtime_i  in  64  current mtime from the timer
- timer_intr_i  in  1  level interrupt from the timer (mtime >= mtimecmp)
- cmp_o  out  64  compare value to the timer
- cmp_we_o  out  1  one-cycle compare write strobe (the write also clears the timer intr_state)
- armed_o  out  N_ALARMS  per-slot armed flags
- expired_o  out  N_ALARMS  one-cycle expiry pulses
- busy_o  out  1  FSM not in IDLE/WAIT

Behaviour:
Reset (synchronous, rst_ni=0 at a clock edge):
- All slots disarmed; deadlines cleared to 0.
- cmp_o = 64'hFFFF_FFFF_FFFF_FFFF; cmp_we_o = 0; expired_o = 0; state = IDLE.
- Reset asserted mid-scan or mid-settle aborts the operation; no pulses are emitted in the reset cycle.

States: IDLE, SCAN, PROGRAM, SETTLE, WAIT.
- req_ready_o = 1 only in IDLE and WAIT.
- Request accepted:
  - ARM: armed[id]=1, deadline[id]=req_deadline_i. An already-armed slot is overwritten.
  - CANCEL: armed[id]=0. Cancelling an unarmed slot is a no-op.
  - Either op then transitions to SCAN with idx=0 and min cleared.
- SCAN: one slot per cycle, idx 0..N_ALARMS-1.
  - If armed[idx] and deadline[idx] <= mtime_i (unsigned 64-bit): pulse expired_o[idx] that cycle and clear armed[idx].
  - Else if armed[idx] and (no min yet or deadline[idx] < min): min = deadline[idx]. Ties keep the lower index.
  - The scan takes exactly N_ALARMS cycles and then moves to PROGRAM.
- PROGRAM: one cycle.
  - cmp_we_o = 1.
  - cmp_o = min if any slot is still armed, else all-ones.
  - Next state is SETTLE if any slot is armed, else IDLE.
- SETTLE: counts SETTLE_CYC cycles, then WAIT. timer_intr_i is ignored here.
- WAIT:
  - timer_intr_i = 1 -> SCAN.
  - A request is accepted -> SCAN.
  - If both occur in the same cycle, the request is applied and a single SCAN covers both.
- IDLE: timer_intr_i is ignored.

Boundary conditions:
- A deadline already in the past on ARM retires during the next SCAN. It pulses even if it is the only slot.
- A deadline that passes between SCAN and PROGRAM makes the timer fire immediately after SETTLE, which triggers a rescan. No alarm is lost.
- A slot cancelled in the same cycle it would expire never pulses, because requests are only taken in IDLE/WAIT.
- Deadline = all-ones is legal. It matches the idle compare value but is tracked as armed.
- mtime wrap-around is not handled; comparison is plain unsigned.
- Minimum latency from an ARM handshake to cmp_we_o is N_ALARMS+1 cycles.
- Latency from timer_intr_i (in WAIT) to expired_o is 1..N_ALARMS cycles.

Decomposition:
- Package rv_timer_alarm_pkg holds:
  - alarm_op_e {ALARM_ARM, ALARM_CANCEL}
  - sched_state_e {IDLE, SCAN, PROGRAM, SETTLE, WAIT}
  - constant CMP_IDLE = 64'hFFFF_FFFF_FFFF_FFFF
- No sub-module. Slot storage, the scan counter and the min register stay in the top; the design is serial, so only one comparator pair is needed.

Test Plan:
- Reset, then idle: cmp_o=all-ones, cmp_we_o=0, req_ready_o=1, armed_o=0, expired_o=0.
- ARM slot2=1000 at mtime=0 -> after 4 SCAN cycles cmp_we_o pulses with cmp_o=1000; armed_o=4'b0100.
- ARM slot0=500 and slot3=500 (slot2 still 1000) -> cmp_o=500. Raise timer_intr_i with mtime=500 -> expired_o[0] and expired_o[3] pulse; next cmp_o=1000.
- ARM slot1=10 while mtime=50 -> expired_o[1] pulses during SCAN; cmp_o is unchanged for the other slots; armed_o[1]=0.
- CANCEL the only armed slot -> PROGRAM writes cmp_o=all-ones, FSM returns to IDLE, no expired pulse. Then hold timer_intr_i=1 -> no action.
- Assert rst_ni=0 mid-SCAN with 3 slots armed -> next cycle everything is at reset values and no expired pulses occur. Also check timer_intr_i held high through SETTLE does not trigger a rescan before WAIT.
